// File: rtl/switch_debouncer_if.sv
// Signal bundle between a raw switch pin and its debouncer.
// The master side drives the raw level; the slave side returns the cleaned level, edge pulses and busy.
interface switch_debouncer_if;
  logic sw_in;
  logic sw_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  modport master (
    output sw_in,
    input  sw_out,
    input  rise_pulse,
    input  fall_pulse,
    input  busy
  );

  modport slave (
    input  sw_in,
    output sw_out,
    output rise_pulse,
    output fall_pulse,
    output busy
  );
endinterface

// File: rtl/switch_debouncer.sv
// Single-switch debouncer: 2-flop synchronizer, free-running sample prescaler and a
// four-state qualifier producing a registered clean level plus one-cycle edge pulses.
module switch_debouncer #(
  parameter int unsigned TICK_DIV     = 25000,
  parameter int unsigned STABLE_COUNT = 10
) (
  input  logic               clk_in,
  input  logic               rst,
  switch_debouncer_if.slave  sw
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = $clog2(STABLE_COUNT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_COUNT - 1);

  typedef enum logic [1:0] {
    S_LOW,
    S_WAIT_H,
    S_HIGH,
    S_WAIT_L
  } state_t;

  logic          s1;
  logic          sw_sync;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [SW-1:0] stab_cnt;
  logic [SW-1:0] stab_cnt_n;
  state_t        state;
  state_t        state_n;
  logic          sw_out_q;
  logic          sw_out_n;
  logic          rise_q;
  logic          rise_n;
  logic          fall_q;
  logic          fall_n;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1      <= 1'b0;
      sw_sync <= 1'b0;
    end else begin
      s1      <= sw.sw_in;
      sw_sync <= s1;
    end
  end

  // Prescaler free-runs; the FSM never resynchronises it, so qualification
  // latency varies by up to one tick period with prescaler phase.
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state    <= S_LOW;
      stab_cnt <= '0;
      sw_out_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state    <= state_n;
      stab_cnt <= stab_cnt_n;
      sw_out_q <= sw_out_n;
      rise_q   <= rise_n;
      fall_q   <= fall_n;
    end
  end

  // Ticks are only counted while already in a WAIT state, so the tick on the
  // entry edge is skipped; the abort test precedes the tick test.
  always_comb begin
    state_n    = state;
    stab_cnt_n = stab_cnt;
    sw_out_n   = sw_out_q;
    rise_n     = 1'b0;
    fall_n     = 1'b0;
    unique case (state)
      S_LOW: begin
        if (sw_sync) begin
          state_n    = S_WAIT_H;
          stab_cnt_n = '0;
        end
      end
      S_WAIT_H: begin
        if (!sw_sync) begin
          state_n = S_LOW;
        end else if (tick) begin
          if (stab_cnt == STAB_LAST) begin
            state_n  = S_HIGH;
            sw_out_n = 1'b1;
            rise_n   = 1'b1;
          end else begin
            stab_cnt_n = stab_cnt + SW'(1);
          end
        end
      end
      S_HIGH: begin
        if (!sw_sync) begin
          state_n    = S_WAIT_L;
          stab_cnt_n = '0;
        end
      end
      S_WAIT_L: begin
        if (sw_sync) begin
          state_n = S_HIGH;
        end else if (tick) begin
          if (stab_cnt == STAB_LAST) begin
            state_n  = S_LOW;
            sw_out_n = 1'b0;
            fall_n   = 1'b1;
          end else begin
            stab_cnt_n = stab_cnt + SW'(1);
          end
        end
      end
      default: begin
        state_n = S_LOW;
      end
    endcase
  end

  assign sw.sw_out     = sw_out_q;
  assign sw.rise_pulse = rise_q;
  assign sw.fall_pulse = fall_q;
  assign sw.busy       = (state == S_WAIT_H) || (state == S_WAIT_L);

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer with TICK_DIV=4, STABLE_COUNT=3: stimulus pushes
// expected pulse events, a negedge monitor pops and checks each pulse the DUT produces.
module tb_switch_debouncer;

  typedef struct {
    bit is_rise;
    int lo;
    int hi;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   e0;
  exp_t sb[$];
  exp_t got;
  logic prev_r = 1'b0;
  logic prev_f = 1'b0;

  switch_debouncer_if dif();

  switch_debouncer #(
    .TICK_DIV     (4),
    .STABLE_COUNT (3)
  ) dut (
    .clk_in (clk),
    .rst    (rst),
    .sw     (dif)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Qualification always completes 11..14 edges after the first sampling edge E0.
  task automatic expect_pulse(input bit is_rise, input int first_edge);
    exp_t e;
    e.is_rise = is_rise;
    e.lo      = first_edge + 11;
    e.hi      = first_edge + 14;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dif.rise_pulse || dif.fall_pulse) begin
        cmp("pulse_exclusive", 32'(dif.rise_pulse & dif.fall_pulse), 0);
        cmp("pulse_width", 32'((dif.rise_pulse & prev_r) | (dif.fall_pulse & prev_f)), 0);
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: rise=%0b fall=%0b at edge %0d, none expected",
                   dif.rise_pulse, dif.fall_pulse, cyc);
        end else begin
          got = sb.pop_front();
          cmp("pulse_kind_rise", 32'(dif.rise_pulse), 32'(got.is_rise));
          cmp("sw_out_at_pulse", 32'(dif.sw_out), 32'(got.is_rise));
          cmp("busy_at_pulse", 32'(dif.busy), 0);
          vectors++;
          if (cyc < got.lo || cyc > got.hi) begin
            miscompares++;
            $display("FAIL pulse_window: pulse at edge %0d, expected edge %0d..%0d",
                     cyc, got.lo, got.hi);
          end
        end
      end
      prev_r <= dif.rise_pulse;
      prev_f <= dif.fall_pulse;
    end else begin
      prev_r <= 1'b0;
      prev_f <= 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at edge %0d", cyc);
    $fatal(1);
  end

  initial begin
    dif.sw_in = 1'b0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    cmp("rst_sw_out", 32'(dif.sw_out), 0);
    cmp("rst_rise", 32'(dif.rise_pulse), 0);
    cmp("rst_fall", 32'(dif.fall_pulse), 0);
    cmp("rst_busy", 32'(dif.busy), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    cmp("idle_sw_out", 32'(dif.sw_out), 0);

    // clean press
    dif.sw_in = 1'b1;
    e0 = cyc + 1;
    expect_pulse(1'b1, e0);
    wait_cyc(e0 + 1);
    cmp("busy_after_e1", 32'(dif.busy), 0);
    wait_cyc(e0 + 2);
    cmp("busy_after_e2", 32'(dif.busy), 1);
    wait_cyc(e0 + 20);
    cmp("press_pulse_pending", sb.size(), 0);
    cmp("press_sw_out", 32'(dif.sw_out), 1);
    cmp("press_busy", 32'(dif.busy), 0);

    // release
    dif.sw_in = 1'b0;
    e0 = cyc + 1;
    expect_pulse(1'b0, e0);
    wait_cyc(e0 + 20);
    cmp("release_pulse_pending", sb.size(), 0);
    cmp("release_sw_out", 32'(dif.sw_out), 0);

    // bounce: 3-cycle segments never survive a full window
    for (int k = 0; k < 10; k++) begin
      dif.sw_in = (k % 2 == 0);
      repeat (3) @(negedge clk);
    end
    cmp("bounce_sw_out", 32'(dif.sw_out), 0);
    dif.sw_in = 1'b1;
    e0 = cyc + 1;
    expect_pulse(1'b1, e0);
    wait_cyc(e0 + 20);
    cmp("bounce_pulse_pending", sb.size(), 0);
    cmp("bounce_sw_out_final", 32'(dif.sw_out), 1);

    // reset mid-qualification of a release
    dif.sw_in = 1'b0;
    repeat (6) @(negedge clk);
    cmp("waitl_busy", 32'(dif.busy), 1);
    cmp("waitl_sw_out", 32'(dif.sw_out), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    cmp("async_rst_sw_out", 32'(dif.sw_out), 0);
    cmp("async_rst_busy", 32'(dif.busy), 0);
    cmp("async_rst_rise", 32'(dif.rise_pulse), 0);
    cmp("async_rst_fall", 32'(dif.fall_pulse), 0);
    @(negedge clk);
    dif.sw_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    e0 = cyc + 1;
    expect_pulse(1'b1, e0);
    wait_cyc(e0 + 20);
    cmp("rst_release_pulse_pending", sb.size(), 0);
    cmp("rst_release_sw_out", 32'(dif.sw_out), 1);

    // abort coincident with the qualifying tick (edge E0+11 after reset)
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cmp("abort_pre_sw_out", 32'(dif.sw_out), 0);
    rst = 1'b0;
    e0 = cyc + 1;
    wait_cyc(e0 + 8);
    dif.sw_in = 1'b0;
    wait_cyc(e0 + 10);
    cmp("abort_busy_before", 32'(dif.busy), 1);
    wait_cyc(e0 + 11);
    cmp("abort_busy_after", 32'(dif.busy), 0);
    cmp("abort_sw_out", 32'(dif.sw_out), 0);
    wait_cyc(e0 + 30);
    cmp("abort_sw_out_late", 32'(dif.sw_out), 0);
    cmp("abort_pending", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
